// File: rtl/ras_ckpt.sv
// -----------------------------------------------------------------------------
// ras_ckpt : parametrised return address stack with checkpoint/restore.
//
// Fetch-stage RAS for the branch predictor. Each cycle it exports its
// pre-update top pointer and valid count as a checkpoint. Restoring that
// checkpoint after a mispredict or flush rewinds the speculative stack.
// When the stack overflows, the pointer wraps and the oldest entry is
// overwritten; the count saturates at RAS_ENTRIES. A push and a pop in the
// same cycle (coroutine return/link) replace the top entry.
//
// Optional feature (compile-time macro RAS_RESTORE_TOS_EN):
//   When defined, a restore also writes restore_target into the entry at
//   restore_index. This repairs a top entry that wrong-path pushes
//   clobbered. When undefined, restore_target is ignored.
//
// Ports:
//   CLK, nRST        clock, asynchronous active-low reset
//   push_valid       call/link predicted; push push_target
//   push_target      return address to push
//   pop_valid        return predicted; pop the top entry
//   pop_target       entry[top] (pre-update, combinational from state)
//   pop_empty        count == 0
//   ckpt_index       current top pointer (pre-update)
//   ckpt_count       current valid count (pre-update)
//   restore_valid    rewind to (restore_index, restore_count); has
//                    priority over push and pop
//   restore_index    snapshot top pointer
//   restore_count    snapshot count (must not exceed RAS_ENTRIES)
//   restore_target   snapshot top entry (RAS_RESTORE_TOS_EN only)
// -----------------------------------------------------------------------------
module ras_ckpt #(
  parameter int RAS_ENTRIES      = 8,
  parameter int RAS_TARGET_WIDTH = 31,
  parameter int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES)
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  output logic [RAS_TARGET_WIDTH-1:0] pop_target,
  output logic                        pop_empty,
  output logic [LOG_RAS_ENTRIES-1:0]  ckpt_index,
  output logic [LOG_RAS_ENTRIES:0]    ckpt_count,
  input  logic                        restore_valid,
  input  logic [LOG_RAS_ENTRIES-1:0]  restore_index,
  input  logic [LOG_RAS_ENTRIES:0]    restore_count,
  input  logic [RAS_TARGET_WIDTH-1:0] restore_target
);

  localparam logic [LOG_RAS_ENTRIES-1:0] TOP_MAX = LOG_RAS_ENTRIES'(RAS_ENTRIES - 1);
  localparam logic [LOG_RAS_ENTRIES-1:0] TOP_ONE = LOG_RAS_ENTRIES'(1);
  localparam logic [LOG_RAS_ENTRIES:0]   CNT_MAX = (LOG_RAS_ENTRIES + 1)'(RAS_ENTRIES);
  localparam logic [LOG_RAS_ENTRIES:0]   CNT_ONE = (LOG_RAS_ENTRIES + 1)'(1);

  logic [RAS_TARGET_WIDTH-1:0] entry_q [RAS_ENTRIES];
  logic [LOG_RAS_ENTRIES-1:0]  top_q;
  logic [LOG_RAS_ENTRIES:0]    count_q;
  logic [LOG_RAS_ENTRIES-1:0]  top_inc;
  logic [LOG_RAS_ENTRIES-1:0]  top_dec;

  // Wrap uses an explicit compare against the last index, not bit
  // truncation. This keeps non-power-of-2 depths correct.
  // NOTE: every signal assigned in always_comb gets a value on every path;
  // otherwise synthesis infers a latch.
  always_comb begin
    top_inc = (top_q == TOP_MAX) ? '0 : top_q + TOP_ONE;
    top_dec = (top_q == '0) ? TOP_MAX : top_q - TOP_ONE;
  end

  // NOTE: all sequential state uses non-blocking assignments. Every
  // always_ff then reads the pre-edge values, whatever the evaluation order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      top_q   <= '0;
      count_q <= '0;
      // NOTE: the entry array is reset as well, so pop_target reads a
      // defined 0 after reset instead of an X from an unwritten entry.
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
    end else if (restore_valid) begin
      // Restore wins. Any push or pop in the same cycle is wrong-path
      // work and is dropped.
      top_q   <= restore_index;
      count_q <= restore_count;
`ifdef RAS_RESTORE_TOS_EN
      entry_q[restore_index] <= restore_target;
`endif
    end else if (push_valid && pop_valid) begin
      // Return and link in the same cycle: replace the top in place.
      entry_q[top_q] <= push_target;
      if (count_q == '0) begin
        count_q <= CNT_ONE;
      end
    end else if (push_valid) begin
      // On overflow the pointer wraps onto the oldest entry and the
      // count stays saturated.
      top_q            <= top_inc;
      entry_q[top_inc] <= push_target;
      if (count_q != CNT_MAX) begin
        count_q <= count_q + CNT_ONE;
      end
    end else if (pop_valid && (count_q != '0)) begin
      top_q   <= top_dec;
      count_q <= count_q - CNT_ONE;
    end
  end

`ifndef RAS_RESTORE_TOS_EN
  // restore_target has no effect in this build.
  logic unused_restore_target;
  assign unused_restore_target = ^restore_target;
`endif

  assign pop_target = entry_q[top_q];
  assign pop_empty  = (count_q == '0);
  assign ckpt_index = top_q;
  assign ckpt_count = count_q;

endmodule
